// File: rtl/web_resource_ctrl.sv
// web_resource_ctrl: resource checker and fire sequencer for the web-choice path.
// Checks fluid/energy/tracer stock against the cost of the chosen web, deducts
// on grant, then runs a cooldown; also runs cartridge reload and energy recharge.
// Optional feature macro: TRACER_RELOAD_EN (reload exit also refills tracers to 63).
module web_resource_ctrl #(
  parameter int unsigned FLUID_MAX       = 12,
  parameter int unsigned TRACER_INIT     = 32,
  parameter int unsigned COOLDOWN_CYCLES = 4,
  parameter int unsigned RELOAD_CYCLES   = 16,
  parameter int unsigned RECHARGE_PERIOD = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] choice,
  input  logic       fire_req,
  input  logic       cartridge_present,
  output logic       busy,
  output logic       fire_ok,
  output logic       deny,
  output logic [2:0] deny_code,
  output logic [2:0] web_id,
  output logic       reload_done,
  output logic [3:0] fluid,
  output logic [7:0] energy,
  output logic [5:0] tracers
);

  localparam int unsigned DIV_W = $clog2(RECHARGE_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CHECK    = 2'd1,
    S_COOLDOWN = 2'd2,
    S_RELOAD   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         choice_q, choice_d;
  logic [2:0]         web_id_q, web_id_d;
  logic [3:0]         fluid_q, fluid_d;
  logic [7:0]         energy_q, energy_d, energy_sub;
  logic [5:0]         tracers_q, tracers_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               fire_ok_q, fire_ok_d;
  logic               deny_q, deny_d;
  logic [2:0]         deny_code_q, deny_code_d;
  logic               reload_done_q, reload_done_d;
  logic               div_wrap;

  // Fluid cost per web index (0 = swing ... 7 = reload).
  function automatic logic [3:0] fluid_cost(input logic [2:0] id);
    case (id)
      3'd0:    fluid_cost = 4'd1;
      3'd1:    fluid_cost = 4'd1;
      3'd2:    fluid_cost = 4'd2;
      3'd3:    fluid_cost = 4'd4;
      3'd4:    fluid_cost = 4'd1;
      3'd5:    fluid_cost = 4'd3;
      default: fluid_cost = 4'd0;
    endcase
  endfunction

  // Energy cost per web index.
  function automatic logic [7:0] energy_cost(input logic [2:0] id);
    case (id)
      3'd1:    energy_cost = 8'd4;
      3'd2:    energy_cost = 8'd2;
      3'd4:    energy_cost = 8'd16;
      3'd5:    energy_cost = 8'd8;
      3'd6:    energy_cost = 8'd1;
      default: energy_cost = 8'd0;
    endcase
  endfunction

  // Tracer cost per web index; only the tracer web consumes one.
  function automatic logic [5:0] tracer_cost(input logic [2:0] id);
    case (id)
      3'd6:    tracer_cost = 6'd1;
      default: tracer_cost = 6'd0;
    endcase
  endfunction

  // True when exactly one bit of the choice vector is set.
  function automatic logic is_onehot(input logic [7:0] v);
    is_onehot = (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Map choice bit position to web index (bit7 -> 0 ... bit0 -> 7).
  function automatic logic [2:0] choice_to_id(input logic [7:0] v);
    choice_to_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        choice_to_id = 3'(7 - i);
      end
    end
  endfunction

  assign div_wrap = (div_q == DIV_W'(RECHARGE_PERIOD - 1));

  // Next-state, resource update and pulse generation.
  always_comb begin
    state_d       = state_q;
    choice_d      = choice_q;
    web_id_d      = web_id_q;
    fluid_d       = fluid_q;
    energy_sub    = energy_q;
    tracers_d     = tracers_q;
    cnt_d         = cnt_q;
    fire_ok_d     = 1'b0;
    deny_d        = 1'b0;
    deny_code_d   = 3'b000;
    reload_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fire_req) begin
          choice_d = choice;
          web_id_d = choice_to_id(choice);
          state_d  = S_CHECK;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (!is_onehot(choice_q)) begin
          deny_d      = 1'b1;
          deny_code_d = 3'b100;
        end else if ((web_id_q == 3'd7) && !cartridge_present) begin
          deny_d      = 1'b1;
          deny_code_d = 3'b101;
        end else if (fluid_q < fluid_cost(web_id_q)) begin
          deny_d      = 1'b1;
          deny_code_d = 3'b001;
        end else if (energy_q < energy_cost(web_id_q)) begin
          deny_d      = 1'b1;
          deny_code_d = 3'b010;
        end else if (tracers_q < tracer_cost(web_id_q)) begin
          deny_d      = 1'b1;
          deny_code_d = 3'b011;
        end else if (web_id_q == 3'd7) begin
          cnt_d   = 16'(RELOAD_CYCLES);
          state_d = S_RELOAD;
        end else begin
          fluid_d    = fluid_q - fluid_cost(web_id_q);
          energy_sub = energy_q - energy_cost(web_id_q);
          tracers_d  = tracers_q - tracer_cost(web_id_q);
          fire_ok_d  = 1'b1;
          cnt_d      = 16'(COOLDOWN_CYCLES);
          state_d    = S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q <= 16'd1) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_COOLDOWN;
        end
      end
      S_RELOAD: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q <= 16'd1) begin
          fluid_d       = 4'(FLUID_MAX);
          reload_done_d = 1'b1;
`ifdef TRACER_RELOAD_EN
          tracers_d     = 6'd63;
`else
          tracers_d     = tracers_q;
`endif
          state_d       = S_IDLE;
        end else begin
          state_d = S_RELOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Recharge applies after any deduction so a coincident wrap nets cost-1.
    if (div_wrap && (energy_sub != 8'hFF)) begin
      energy_d = energy_sub + 8'd1;
    end else begin
      energy_d = energy_sub;
    end
    if (div_wrap) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      choice_q      <= 8'd0;
      web_id_q      <= 3'd0;
      fluid_q       <= 4'(FLUID_MAX);
      energy_q      <= 8'd255;
      tracers_q     <= 6'(TRACER_INIT);
      div_q         <= '0;
      cnt_q         <= 16'd0;
      busy_q        <= 1'b0;
      fire_ok_q     <= 1'b0;
      deny_q        <= 1'b0;
      deny_code_q   <= 3'b000;
      reload_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      choice_q      <= choice_d;
      web_id_q      <= web_id_d;
      fluid_q       <= fluid_d;
      energy_q      <= energy_d;
      tracers_q     <= tracers_d;
      div_q         <= div_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      fire_ok_q     <= fire_ok_d;
      deny_q        <= deny_d;
      deny_code_q   <= deny_code_d;
      reload_done_q <= reload_done_d;
    end
  end

  assign busy        = busy_q;
  assign fire_ok     = fire_ok_q;
  assign deny        = deny_q;
  assign deny_code   = deny_code_q;
  assign web_id      = web_id_q;
  assign reload_done = reload_done_q;
  assign fluid       = fluid_q;
  assign energy      = energy_q;
  assign tracers     = tracers_q;

endmodule

// File: tb/tb_web_resource_ctrl.sv
// Directed testbench for web_resource_ctrl with hand-computed expectations.
module tb_web_resource_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] choice = 8'd0;
  logic       fire_req = 1'b0;
  logic       cartridge_present = 1'b0;
  logic       busy, fire_ok, deny, reload_done;
  logic [2:0] deny_code, web_id;
  logic [3:0] fluid;
  logic [7:0] energy;
  logic [5:0] tracers;

  int checks = 0;
  int failures = 0;

  web_resource_ctrl dut (
    .clk(clk), .reset(reset), .choice(choice), .fire_req(fire_req),
    .cartridge_present(cartridge_present), .busy(busy), .fire_ok(fire_ok),
    .deny(deny), .deny_code(deny_code), .web_id(web_id),
    .reload_done(reload_done), .fluid(fluid), .energy(energy), .tracers(tracers)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    fire_req = 1'b0;
    choice = 8'd0;
    cartridge_present = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Issue one request and observe the whole busy window (bounded).
  task automatic do_request(input logic [7:0] ch, input logic cp,
                            output int busy_n, output int ok_n, output int deny_n,
                            output logic [2:0] code, output int done_n);
    busy_n = 0; ok_n = 0; deny_n = 0; code = 3'd0; done_n = 0;
    choice = ch;
    cartridge_present = cp;
    fire_req = 1'b1;
    tick();
    fire_req = 1'b0;
    while (busy && busy_n < 40) begin
      busy_n++;
      tick();
      if (fire_ok) ok_n++;
      if (deny) begin
        deny_n++;
        code = deny_code;
      end
      if (reload_done) done_n++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    checks++; if (fire_ok !== 1'b0 || deny !== 1'b0 || reload_done !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b%b exp=000", fire_ok, deny, reload_done); end
    checks++; if (deny_code !== 3'd0 || web_id !== 3'd0) begin failures++; $display("FAIL reset_codes got=%0d/%0d exp=0/0", deny_code, web_id); end
    checks++; if (fluid !== 4'd12) begin failures++; $display("FAIL reset_fluid got=%0d exp=12", fluid); end
    checks++; if (energy !== 8'd255) begin failures++; $display("FAIL reset_energy got=%0d exp=255", energy); end
    checks++; if (tracers !== 6'd32) begin failures++; $display("FAIL reset_tracers got=%0d exp=32", tracers); end
  endtask

  task automatic test_grenade();
    int bn, okn, dn, don;
    logic [2:0] code;
    logic [3:0] exp_fluid;
    apply_reset();
    exp_fluid = 4'd12;
    for (int k = 0; k < 3; k++) begin
      do_request(8'b00010000, 1'b0, bn, okn, dn, code, don);
      exp_fluid = exp_fluid - 4'd4;
      checks++; if (okn !== 1) begin failures++; $display("FAIL grenade_fire_ok got=%0d exp=1", okn); end
      checks++; if (bn !== 5) begin failures++; $display("FAIL grenade_busy got=%0d exp=5", bn); end
      checks++; if (fluid !== exp_fluid) begin failures++; $display("FAIL grenade_fluid got=%0d exp=%0d", fluid, exp_fluid); end
      checks++; if (web_id !== 3'd3) begin failures++; $display("FAIL grenade_web_id got=%0d exp=3", web_id); end
    end
    do_request(8'b00010000, 1'b0, bn, okn, dn, code, don);
    checks++; if (dn !== 1 || code !== 3'b001) begin failures++; $display("FAIL grenade_empty_deny got=%0d/%b exp=1/001", dn, code); end
    checks++; if (okn !== 0 || bn !== 1) begin failures++; $display("FAIL grenade_empty_busy got=ok%0d busy%0d exp=ok0 busy1", okn, bn); end
    checks++; if (fluid !== 4'd0 || energy !== 8'd255) begin failures++; $display("FAIL grenade_empty_res got=%0d/%0d exp=0/255", fluid, energy); end
  endtask

  task automatic test_reload();
    int bn, okn, dn, don;
    logic [2:0] code;
    do_request(8'b00000001, 1'b0, bn, okn, dn, code, don);
    checks++; if (dn !== 1 || code !== 3'b101 || bn !== 1) begin failures++; $display("FAIL reload_no_cart got=%0d/%b/%0d exp=1/101/1", dn, code, bn); end
    checks++; if (fluid !== 4'd0) begin failures++; $display("FAIL reload_no_cart_fluid got=%0d exp=0", fluid); end
    // Reload with fire_req pulses and choice changes during RELOAD.
    bn = 0; don = 0; okn = 0;
    choice = 8'b00000001;
    cartridge_present = 1'b1;
    fire_req = 1'b1;
    tick();
    fire_req = 1'b0;
    choice = 8'b00010000;
    while (busy && bn < 40) begin
      bn++;
      fire_req = ~fire_req;
      tick();
      if (reload_done) don++;
      if (fire_ok) okn++;
    end
    fire_req = 1'b0;
    checks++; if (bn !== 17) begin failures++; $display("FAIL reload_busy got=%0d exp=17", bn); end
    checks++; if (don !== 1 || okn !== 0) begin failures++; $display("FAIL reload_pulses got=done%0d ok%0d exp=done1 ok0", don, okn); end
    checks++; if (fluid !== 4'd12) begin failures++; $display("FAIL reload_fluid got=%0d exp=12", fluid); end
    checks++; if (web_id !== 3'd7) begin failures++; $display("FAIL reload_web_id got=%0d exp=7", web_id); end
    bn = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy) bn++;
    end
    checks++; if (bn !== 0 || fluid !== 4'd12) begin failures++; $display("FAIL reload_dropped_req got=busy%0d fluid%0d exp=busy0 fluid12", bn, fluid); end
  endtask

  task automatic test_onehot();
    int bn, okn, dn, don;
    logic [2:0] code;
    do_request(8'b11000000, 1'b1, bn, okn, dn, code, don);
    checks++; if (dn !== 1 || code !== 3'b100 || okn !== 0) begin failures++; $display("FAIL onehot_multi got=%0d/%b ok%0d exp=1/100 ok0", dn, code, okn); end
    do_request(8'b00000000, 1'b1, bn, okn, dn, code, don);
    checks++; if (dn !== 1 || code !== 3'b100 || bn !== 1) begin failures++; $display("FAIL onehot_zero got=%0d/%b busy%0d exp=1/100 busy1", dn, code, bn); end
    checks++; if (fluid !== 4'd12 || energy !== 8'd255 || tracers !== 6'd32) begin failures++; $display("FAIL onehot_res got=%0d/%0d/%0d exp=12/255/32", fluid, energy, tracers); end
  endtask

  task automatic test_tracer();
    int bn, okn, dn, don, grants;
    logic [2:0] code;
    apply_reset();
    grants = 0;
    for (int k = 0; k < 32; k++) begin
      do_request(8'b00000010, 1'b1, bn, okn, dn, code, don);
      grants += okn;
    end
    checks++; if (grants !== 32) begin failures++; $display("FAIL tracer_grants got=%0d exp=32", grants); end
    checks++; if (tracers !== 6'd0) begin failures++; $display("FAIL tracer_count got=%0d exp=0", tracers); end
    // 32 deductions, wraps at edges 64/128/192: 255-32+3.
    checks++; if (energy !== 8'd226) begin failures++; $display("FAIL tracer_energy got=%0d exp=226", energy); end
    checks++; if (fluid !== 4'd12) begin failures++; $display("FAIL tracer_fluid got=%0d exp=12", fluid); end
    do_request(8'b00000010, 1'b1, bn, okn, dn, code, don);
    checks++; if (dn !== 1 || code !== 3'b011 || okn !== 0) begin failures++; $display("FAIL tracer_empty got=%0d/%b ok%0d exp=1/011 ok0", dn, code, okn); end
    checks++; if (energy !== 8'd226) begin failures++; $display("FAIL tracer_empty_energy got=%0d exp=226", energy); end
    do_request(8'b00000001, 1'b1, bn, okn, dn, code, don);
    checks++; if (don !== 1 || bn !== 17) begin failures++; $display("FAIL tracer_reload got=done%0d busy%0d exp=done1 busy17", don, bn); end
`ifdef TRACER_RELOAD_EN
    checks++; if (tracers !== 6'd63) begin failures++; $display("FAIL tracer_refill got=%0d exp=63", tracers); end
`else
    checks++; if (tracers !== 6'd0) begin failures++; $display("FAIL tracer_no_refill got=%0d exp=0", tracers); end
`endif
  endtask

  task automatic test_taser_recharge();
    int bn, okn, dn, don;
    logic [2:0] code;
    apply_reset();
    do_request(8'b00001000, 1'b0, bn, okn, dn, code, don);
    checks++; if (okn !== 1 || web_id !== 3'd4) begin failures++; $display("FAIL taser_grant got=ok%0d id%0d exp=ok1 id4", okn, web_id); end
    checks++; if (energy !== 8'd239 || fluid !== 4'd11) begin failures++; $display("FAIL taser_deduct got=%0d/%0d exp=239/11", energy, fluid); end
    repeat (57) tick();
    checks++; if (energy !== 8'd239) begin failures++; $display("FAIL recharge_before_wrap got=%0d exp=239", energy); end
    tick();
    checks++; if (energy !== 8'd240) begin failures++; $display("FAIL recharge_wrap got=%0d exp=240", energy); end
  endtask

  task automatic test_reset_mid_reload();
    int bn, okn, dn, don;
    logic [2:0] code;
    apply_reset();
    do_request(8'b00010000, 1'b0, bn, okn, dn, code, don);
    choice = 8'b00000001;
    cartridge_present = 1'b1;
    fire_req = 1'b1;
    tick();
    fire_req = 1'b0;
    repeat (5) tick();
    checks++; if (busy !== 1'b1 || fluid !== 4'd8) begin failures++; $display("FAIL midreload_state got=busy%0d fluid%0d exp=busy1 fluid8", busy, fluid); end
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || fluid !== 4'd12 || reload_done !== 1'b0) begin failures++; $display("FAIL midreload_reset got=busy%0d fluid%0d done%0d exp=0/12/0", busy, fluid, reload_done); end
    reset = 1'b0;
    don = 0; bn = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (reload_done) don++;
      if (busy) bn++;
    end
    checks++; if (don !== 0 || bn !== 0) begin failures++; $display("FAIL midreload_aftermath got=done%0d busy%0d exp=0/0", don, bn); end
  endtask

  initial begin
    test_reset();
    test_grenade();
    test_reload();
    test_onehot();
    test_tracer();
    test_taser_recharge();
    test_reset_mid_reload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
